// File: rtl/port_bus_pkg.sv
// port_bus_pkg: shared widths, read-latency limit and FSM state encoding for the strobed port bus
package port_bus_pkg;
    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 16;
    localparam int READ_LAT_MAX = 3;
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WAIT, RESP} pb_state_t;
endpackage

// File: rtl/port_bus_master.sv
// port_bus_master: initiator of the 16-bit strobed port bus with setup/strobe/hold sequencing
// Ports: cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata - single read/write command channel
//        rsp_valid/rsp_ready/rsp_rdata                   - read response channel
//        port_id/out_port/write_strobe/read_strobe/in_port - downstream port bus
//        busy - transaction in progress; reset_n - asynchronous active-low reset
module port_bus_master
    import port_bus_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] port_id,
    output logic [DATA_W-1:0] out_port,
    output logic              write_strobe,
    output logic              read_strobe,
    input  logic [DATA_W-1:0] in_port,
    output logic              busy
);
    if (READ_LAT < 0 || READ_LAT > READ_LAT_MAX) begin : g_bad_read_lat
        $error("port_bus_master: READ_LAT %0d outside 0..%0d", READ_LAT, READ_LAT_MAX);
    end

    // Count value of the final WAIT cycle; unused when READ_LAT is 0
    localparam logic [1:0] LAST_WAIT = 2'((READ_LAT > 0) ? READ_LAT - 1 : 0);

    pb_state_t  state, state_nx;
    logic       wr;
    logic [1:0] cnt, cnt_nx;
    logic       accept, sample;

    assign accept       = cmd_valid & cmd_ready;
    assign busy         = (state != IDLE);
    assign rsp_valid    = (state == RESP);
    // Strobes decode straight from the state register so an async reset drops them at once
    assign write_strobe = (state == STROBE) &  wr;
    assign read_strobe  = (state == STROBE) & ~wr;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sample   = 1'b0;
        case (state)
            IDLE:   state_nx = accept ? SETUP : IDLE;
            SETUP:  state_nx = STROBE;
            STROBE: begin
                if (wr) begin
                    state_nx = HOLD;
                end else if (READ_LAT == 0) begin
                    sample   = 1'b1;
                    state_nx = RESP;
                end else begin
                    state_nx = WAIT;
                    cnt_nx   = 2'd0;
                end
            end
            HOLD:   state_nx = IDLE;
            WAIT: begin
                if (cnt == LAST_WAIT) begin
                    sample   = 1'b1;
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt + 2'd1;
                end
            end
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            wr        <= 1'b0;
            cmd_ready <= 1'b0;
            port_id   <= '0;
            out_port  <= '0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            // Registered ready: high exactly when the next state is IDLE
            cmd_ready <= (state_nx == IDLE);
            if (accept) begin
                wr      <= cmd_write;
                port_id <= cmd_addr;
                if (cmd_write) out_port <= cmd_wdata;
            end
            if (sample) rsp_rdata <= in_port;
        end
    end
endmodule

// File: doc/port_bus_master.md
# port_bus_master

Initiator side of the 16-bit strobed port bus: accepts single read/write commands on a valid/ready interface and drives `port_id`, `out_port`, `write_strobe` and `read_strobe` with fixed setup/strobe/hold sequencing. For reads it samples `in_port` after a configurable latency and returns the data on a valid/ready response channel. It sits between a command source (UART command parser or test controller) and the downstream one-hot port decoder and peripherals.

## Interface
- `ADDR_W`, 16: width of `port_id`/`cmd_addr`.
- `DATA_W`, 16: width of the data paths.
- `READ_LAT`, 1: cycles from the `read_strobe` cycle to `in_port` being valid. Legal range 0..3; any other value is an elaboration error.

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  target port.
- `cmd_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes read data.
- `rsp_rdata`  out  DATA_W  read data.
- `port_id`  out  ADDR_W  bus address.
- `out_port`  out  DATA_W  bus write data.
- `write_strobe`  out  1  one-cycle write pulse.
- `read_strobe`  out  1  one-cycle read pulse.
- `in_port`  in  DATA_W  bus read data from the peripheral mux.
- `busy`  out  1  state is not IDLE.

## Operation
- **FSM states:** IDLE, SETUP, STROBE, HOLD (write), WAIT (read latency), RESP (read).
- **Accept:** a command is accepted on a rising edge where `cmd_valid & cmd_ready`. The block latches `cmd_write`, drives `cmd_addr` onto `port_id` and `cmd_wdata` onto `out_port` (writes only), and goes to SETUP.
- **SETUP:** strobes low; `port_id`/`out_port` stable. Next state is STROBE.
- **STROBE:** exactly one of `write_strobe`/`read_strobe` is high for exactly one cycle.
  - Write: next state HOLD.
  - Read with `READ_LAT`=0: samples `in_port` at the closing edge and goes to RESP.
  - Read with `READ_LAT`>0: goes to WAIT.
- **HOLD:** strobes low, bus held for one cycle, then IDLE.
- **WAIT:** a 2-bit counter runs `READ_LAT` cycles. `in_port` is sampled at the edge closing the last WAIT cycle, then RESP.
- **RESP:** `rsp_valid` is high and `rsp_rdata` is stable until `rsp_ready` is high at an edge, then IDLE.
- **Outside a transaction:** `port_id`/`out_port` hold their last values in IDLE. Reads leave `out_port` unchanged.
- **Strobe exclusivity:** the two strobes are never high together, and there is at most one strobe per command.
- `cmd_*` inputs are ignored while `cmd_ready` is low. `rsp_ready` is ignored outside RESP.
- `cmd_ready` is registered. It is high only in IDLE, and low in the accept cycle's successor.

## Timing
- **Reset values:** `cmd_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `port_id`=0, `out_port`=0, `write_strobe`=0, `read_strobe`=0, `busy`=0, state IDLE.
- `cmd_ready` rises at the first clock edge after `reset_n` deasserts.
- **Write, accepted at edge E0:** SETUP in cycle E0+1, `write_strobe` in cycle E0+2, HOLD in E0+3, `cmd_ready` high in E0+4. Throughput is one write per 4 cycles.
- **Read, accepted at E0:** `read_strobe` in cycle E0+2. `rsp_valid` first high in cycle E0+3+`READ_LAT`.
  - Minimum 4+`READ_LAT` cycles accept-to-`cmd_ready` when `rsp_ready` is held high.
- If `rsp_ready` is already high when `rsp_valid` rises, `rsp_valid` lasts exactly one cycle.
- **Reset mid-transaction:** all outputs return to reset values asynchronously. Strobes drop immediately. Any pending response is discarded with no partial pulse after release.

## Structure
- Shared package `port_bus_pkg` holds:
  - default `ADDR_W`/`DATA_W`;
  - the `READ_LAT` legal maximum;
  - the FSM state enum (shared with the bus monitor used in verification).
- No sub-module. The latency counter and FSM live in one module.

## Test plan
- **Write:** write `cmd_addr`=0x0005, `cmd_wdata`=0xA5C3 → `port_id`=0x0005 from E0+1 to E0+3; `out_port`=0xA5C3; single `write_strobe` in E0+2; `cmd_ready` back in E0+4.
- **Read latency sweep:** read 0x000C, `READ_LAT`=1, `in_port`=0x1234 only in cycle E0+3 (garbage otherwise) → `rsp_rdata`=0x1234 with `rsp_valid` in E0+4. Repeat for `READ_LAT`=0/3 with a correspondingly shifted valid window.
- **Response backpressure:** hold `rsp_ready` low 5 cycles → `rsp_valid` and `rsp_rdata` stable, `cmd_ready` low, no strobes. Release → IDLE next cycle.
- **Back-to-back mixed traffic:** `cmd_valid` held high with write/read/write → strobes spaced exactly per the latency rules, never overlapping, one per command, in order.
- **Reset mid-strobe:** assert `reset_n`=0 during the `read_strobe` cycle → strobe falls without waiting for a clock edge, all outputs at reset values. After release: `cmd_ready` is 0 until the first edge, and no response is emitted.
